// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU pipeline controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } ctrl_state_e;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OPC_W-1:0] HALT_OPC_DEF = 6'h3F;

    // Opcodes used upstream to derive id_uses_rt.
    localparam logic [OPC_W-1:0] OPC_R_TYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_J      = 6'h02;
    localparam logic [OPC_W-1:0] OPC_BEQ    = 6'h04;
    localparam logic [OPC_W-1:0] OPC_LW     = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW     = 6'h2B;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: stage enables/flushes for load-use stall,
// MEM-resolved redirects, host pause and HALT drain, plus perf counters.
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned      CNT_W     = 32,
    parameter int unsigned      DRAIN_CYC = 3,
    parameter logic [OPC_W-1:0] HALT_OPC  = HALT_OPC_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_waddr,
    input  logic             mem_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    ctrl_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               ret_drain_q, ret_drain_d;
    logic               cyc_inc, stall_inc;
    logic               load_use, is_halt;

    // ex_waddr==0 is the hardwired zero register and never creates a hazard.
    assign load_use = ex_mem_read && (ex_waddr != 5'd0) &&
                      ((ex_waddr == id_rs) || (id_uses_rt && (ex_waddr == id_rt)));
    assign is_halt  = (id_opcode == HALT_OPC);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            ret_drain_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ret_drain_q <= ret_drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        ret_drain_d = ret_drain_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        cyc_inc     = 1'b0;
        stall_inc   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!enable) begin
                    state_d     = ST_PAUSE;
                    ret_drain_d = 1'b0;
                end else begin
                    cyc_inc  = 1'b1;
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    if (mem_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (is_halt) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        drain_d    = DRAIN_W'(DRAIN_CYC);
                        state_d    = ST_DRAIN;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
            end

            ST_PAUSE: begin
                if (enable) begin
                    state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (!enable) begin
                    state_d     = ST_PAUSE;
                    ret_drain_d = 1'b1;
                end else if (mem_redirect) begin
                    // An older taken branch makes the HALT wrong-path.
                    cyc_inc     = 1'b1;
                    stall_inc   = 1'b1;
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    drain_d     = '0;
                    state_d     = ST_RUN;
                end else begin
                    cyc_inc    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                    if (drain_q <= DRAIN_W'(1)) begin
                        drain_d = '0;
                        state_d = ST_HALT;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign halted  = (state_q == ST_HALT);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (cyc_inc),
        .cnt    (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (stall_inc),
        .cnt    (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, run, load-use, redirect, drain,
// pause-in-drain, async reset and counter saturation.
module tb_pipeline_ctrl;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_waddr;
    logic        mem_redirect;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        running, halted;
    logic [31:0] cycle_cnt, stall_cnt;

    logic        sat_rst_n, sat_inc;
    logic [2:0]  sat_cnt;

    logic [7:0]  ctl;

    int n_vec = 0;
    int n_err = 0;

    // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes}
    localparam logic [7:0] C_OFF   = 8'b00000_000;
    localparam logic [7:0] C_RUN   = 8'b11111_000;
    localparam logic [7:0] C_REDIR = 8'b11111_111;
    localparam logic [7:0] C_HALT  = 8'b01111_110;
    localparam logic [7:0] C_STALL = 8'b00111_010;
    localparam logic [7:0] C_DRAIN = 8'b00111_010;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush};

    pipeline_ctrl #(.CNT_W(32), .DRAIN_CYC(3), .HALT_OPC(6'h3F)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_waddr     (ex_waddr),
        .mem_redirect (mem_redirect),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .running      (running),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .stall_cnt    (stall_cnt)
    );

    sat_counter #(.W(3)) u_sat (
        .clk    (clk),
        .arst_n (sat_rst_n),
        .inc    (sat_inc),
        .cnt    (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_opcode    = 6'h00;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_uses_rt   = 1'b0;
        ex_mem_read  = 1'b0;
        ex_waddr     = 5'd0;
        mem_redirect = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        enable = 1'b0;
        clear_in();
        tick();
        tick();
        arst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        enable = 1'b1;
        clear_in();
        #2;
        n_vec++;
        if (ctl !== C_OFF) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, C_OFF);
        end
        n_vec++;
        if ({running, halted} !== 2'b00) begin
            n_err++; $display("FAIL reset_state: got %b want 00", {running, halted});
        end
        n_vec++;
        if ((cycle_cnt !== 32'd0) || (stall_cnt !== 32'd0)) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, stall_cnt);
        end
        do_reset();
        enable = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_OFF) begin
            n_err++; $display("FAIL idle_ctl: got %b want %b", ctl, C_OFF);
        end
    endtask

    task automatic test_run_pause();
        do_reset();
        enable = 1'b1;
        tick();
        n_vec++;
        if (running !== 1'b1 || ctl !== C_RUN) begin
            n_err++; $display("FAIL run_entry: got run=%b ctl=%b want 1 %b", running, ctl, C_RUN);
        end
        repeat (10) tick();
        n_vec++;
        if (cycle_cnt !== 32'd10 || stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL run_cnt: got %0d/%0d want 10/0", cycle_cnt, stall_cnt);
        end
        enable = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_OFF) begin
            n_err++; $display("FAIL pause_ctl: got %b want %b", ctl, C_OFF);
        end
        repeat (3) tick();
        n_vec++;
        if (running !== 1'b0 || cycle_cnt !== 32'd10) begin
            n_err++; $display("FAIL pause_frozen: got run=%b cyc=%0d want 0 10", running, cycle_cnt);
        end
        enable = 1'b1;
        tick();
        n_vec++;
        if (running !== 1'b1 || ctl !== C_RUN || cycle_cnt !== 32'd10) begin
            n_err++; $display("FAIL resume: got run=%b ctl=%b cyc=%0d want 1 %b 10",
                              running, ctl, cycle_cnt, C_RUN);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        enable = 1'b1;
        tick();
        ex_mem_read = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
        #1;
        n_vec++;
        if (ctl !== C_STALL) begin
            n_err++; $display("FAIL lu_rs: got %b want %b", ctl, C_STALL);
        end
        tick();
        clear_in();
        #1;
        n_vec++;
        if (ctl !== C_RUN || stall_cnt !== 32'd1 || cycle_cnt !== 32'd1) begin
            n_err++; $display("FAIL lu_after: got ctl=%b stall=%0d cyc=%0d want %b 1 1",
                              ctl, stall_cnt, cycle_cnt, C_RUN);
        end
        ex_mem_read = 1'b1; ex_waddr = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_RUN) begin
            n_err++; $display("FAIL lu_r0: got %b want %b", ctl, C_RUN);
        end
        tick();
        ex_waddr = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_RUN) begin
            n_err++; $display("FAIL lu_rt_unused: got %b want %b", ctl, C_RUN);
        end
        id_uses_rt = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_STALL) begin
            n_err++; $display("FAIL lu_rt: got %b want %b", ctl, C_STALL);
        end
        tick();
        clear_in();
        #1;
        n_vec++;
        if (stall_cnt !== 32'd2) begin
            n_err++; $display("FAIL lu_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        enable = 1'b1;
        tick();
        ex_mem_read = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5;
        id_opcode = 6'h3F; mem_redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_REDIR) begin
            n_err++; $display("FAIL redir_ctl: got %b want %b", ctl, C_REDIR);
        end
        tick();
        clear_in();
        #1;
        n_vec++;
        if (ctl !== C_RUN || running !== 1'b1 || stall_cnt !== 32'd1) begin
            n_err++; $display("FAIL redir_after: got ctl=%b run=%b stall=%0d want %b 1 1",
                              ctl, running, stall_cnt, C_RUN);
        end
    endtask

    task automatic test_halt_drain();
        do_reset();
        enable = 1'b1;
        tick();
        id_opcode = 6'h3F;
        #1;
        n_vec++;
        if (ctl !== C_HALT) begin
            n_err++; $display("FAIL halt_ctl: got %b want %b", ctl, C_HALT);
        end
        tick();
        id_opcode = 6'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (ctl !== C_DRAIN || halted !== 1'b0 || running !== 1'b1) begin
                n_err++; $display("FAIL drain_%0d: got ctl=%b h=%b r=%b want %b 0 1",
                                  i, ctl, halted, running, C_DRAIN);
            end
            tick();
        end
        n_vec++;
        if (halted !== 1'b1 || running !== 1'b0 || ctl !== C_OFF) begin
            n_err++; $display("FAIL halted: got h=%b r=%b ctl=%b want 1 0 %b",
                              halted, running, ctl, C_OFF);
        end
        n_vec++;
        if (cycle_cnt !== 32'd4) begin
            n_err++; $display("FAIL halt_cyc: got %0d want 4", cycle_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            enable = i[0];
            tick();
        end
        enable = 1'b1;
        tick();
        n_vec++;
        if (halted !== 1'b1 || ctl !== C_OFF || cycle_cnt !== 32'd4) begin
            n_err++; $display("FAIL halt_sticky: got h=%b ctl=%b cyc=%0d want 1 %b 4",
                              halted, ctl, cycle_cnt, C_OFF);
        end
    endtask

    task automatic test_drain_redirect();
        do_reset();
        enable = 1'b1;
        tick();
        id_opcode = 6'h3F;
        tick();
        id_opcode = 6'h00;
        tick();
        mem_redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_REDIR) begin
            n_err++; $display("FAIL dredir_ctl: got %b want %b", ctl, C_REDIR);
        end
        tick();
        mem_redirect = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_RUN || running !== 1'b1 || stall_cnt !== 32'd1) begin
            n_err++; $display("FAIL dredir_run: got ctl=%b r=%b stall=%0d want %b 1 1",
                              ctl, running, stall_cnt, C_RUN);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (halted !== 1'b0) begin
                n_err++; $display("FAIL dredir_nohalt_%0d: got %b want 0", i, halted);
            end
        end
    endtask

    task automatic test_drain_pause();
        do_reset();
        enable = 1'b1;
        tick();
        id_opcode = 6'h3F;
        tick();
        id_opcode = 6'h00;
        tick();
        enable = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_OFF) begin
            n_err++; $display("FAIL dpause_ctl: got %b want %b", ctl, C_OFF);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (ctl !== C_OFF || cycle_cnt !== 32'd2 || running !== 1'b0) begin
                n_err++; $display("FAIL dpause_hold_%0d: got ctl=%b cyc=%0d r=%b want %b 2 0",
                                  i, ctl, cycle_cnt, running, C_OFF);
            end
            tick();
        end
        enable = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (ctl !== C_DRAIN || halted !== 1'b0) begin
                n_err++; $display("FAIL dresume_%0d: got ctl=%b h=%b want %b 0",
                                  i, ctl, halted, C_DRAIN);
            end
            tick();
        end
        n_vec++;
        if (halted !== 1'b1 || cycle_cnt !== 32'd4) begin
            n_err++; $display("FAIL dresume_halt: got h=%b cyc=%0d want 1 4", halted, cycle_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        tick();
        id_opcode = 6'h3F;
        tick();
        id_opcode = 6'h00;
        tick();
        #2;
        arst_n = 1'b0;
        #1;
        n_vec++;
        if (running !== 1'b0 || halted !== 1'b0 || ctl !== C_OFF) begin
            n_err++; $display("FAIL areset_state: got r=%b h=%b ctl=%b want 0 0 %b",
                              running, halted, ctl, C_OFF);
        end
        n_vec++;
        if (cycle_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", cycle_cnt, stall_cnt);
        end
    endtask

    task automatic test_saturate();
        sat_rst_n = 1'b1;
        sat_inc   = 1'b1;
        repeat (6) tick();
        n_vec++;
        if (sat_cnt !== 3'd6) begin
            n_err++; $display("FAIL sat_count: got %0d want 6", sat_cnt);
        end
        repeat (4) tick();
        n_vec++;
        if (sat_cnt !== 3'd7) begin
            n_err++; $display("FAIL sat_hold: got %0d want 7", sat_cnt);
        end
        sat_inc = 1'b0;
    endtask

    initial begin
        sat_rst_n = 1'b0;
        sat_inc   = 1'b0;
        test_reset();
        test_run_pause();
        test_load_use();
        test_redirect();
        test_halt_drain();
        test_drain_redirect();
        test_drain_pause();
        test_async_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
